wire_cut_judge: RTL and testbench

// - Downstream of the maze stage: consumes its wire_to_cut verdict and judges the player's physical wire cuts.
// - Player cuts wires by switching wire_sw bits high->low. A correct cut disarms the module; wrong cuts add strikes.
// - Runs a seconds countdown. Reports SOLVED or EXPLODED to the game top level and the OLED/LED status logic.

---
 rtl/wire_judge_pkg.sv | 18 +
 rtl/switch_cut_detector.sv | 67 ++++++
 rtl/wire_cut_judge.sv | 143 ++++++++++++++
 tb/tb_wire_cut_judge.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wire_judge_pkg.sv
// Shared definitions for the wire-cut judge.
// Contents:
//   state_e  - game state encoding as seen on state_o
//   TIME_W   - width of the seconds countdown
//   STRIKE_W - width of the strike counter
package wire_judge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ARMED    = 2'd1,
        ST_SOLVED   = 2'd2,
        ST_EXPLODED = 2'd3
    } state_e;

    localparam int TIME_W   = 8;
    localparam int STRIKE_W = 2;

endpackage

// File: rtl/switch_cut_detector.sv
// Turns raw wire switches into clean, single-cycle cut events.
// Each wire goes through a 2-FF synchroniser and a debounce counter. The
// debounced level only changes after the synchronised input has differed
// from it for DEBOUNCE_CYCLES consecutive cycles. A debounced 1->0 change
// raises cut_evt_o for exactly one cycle; 0->1 changes update the level
// silently.
// Ports:
//   clk_i       system clock
//   rst_ni      asynchronous active-low reset
//   wire_raw_i  raw switches, 1 = intact, 0 = cut
//   cut_evt_o   one-cycle cut event per wire
//   level_o     debounced wire levels
module switch_cut_detector #(
    parameter int NUM_WIRES       = 4,
    parameter int DEBOUNCE_CYCLES = 200_000
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NUM_WIRES-1:0] wire_raw_i,
    output logic [NUM_WIRES-1:0] cut_evt_o,
    output logic [NUM_WIRES-1:0] level_o
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_WIRES-1:0] sync1_q;
    logic [NUM_WIRES-1:0] sync2_q;
    logic [NUM_WIRES-1:0] level_q;
    logic [NUM_WIRES-1:0] evt_q;
    logic [CNT_W-1:0]     cnt_q [NUM_WIRES];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            evt_q   <= '0;
            for (int i = 0; i < NUM_WIRES; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= wire_raw_i;
            sync2_q <= sync1_q;
            for (int i = 0; i < NUM_WIRES; i++) begin
                evt_q[i] <= 1'b0;
                if (sync2_q[i] != level_q[i]) begin
                    if (cnt_q[i] == CNT_LAST) begin
                        level_q[i] <= sync2_q[i];
                        cnt_q[i]   <= '0;
                        // Differing from a high level means the new level is low: a cut.
                        evt_q[i]   <= level_q[i];
                    end else begin
                        cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                    end
                end else begin
                    // Any bounce back to the accepted level restarts the hold time.
                    cnt_q[i] <= '0;
                end
            end
        end
    end

    assign cut_evt_o = evt_q;
    assign level_o   = level_q;

endmodule

// File: rtl/wire_cut_judge.sv
// Judges the player's wire cuts against the maze stage's verdict and runs
// the bomb countdown.
// Ports:
//   CLK, RST_N    clock and asynchronous active-low reset
//   start         one-cycle pulse: arm, or re-arm from any state
//   pausesw       1 freezes the countdown (cuts are still judged)
//   wire_sw       raw wire switches, 1 = intact, 0 = cut
//   wire_to_cut   target wire 1..NUM_WIRES, 0 = no target yet
//   state_o       IDLE / ARMED / SOLVED / EXPLODED
//   strikes       strikes since the last arm
//   strike_pulse  one-cycle pulse per strike
//   time_left     seconds remaining
module wire_cut_judge
    import wire_judge_pkg::*;
#(
    parameter int NUM_WIRES       = 4,
    parameter int CLK_HZ          = 100_000_000,
    parameter int TIME_SECS       = 120,
    parameter int MAX_STRIKES     = 3,
    parameter int DEBOUNCE_CYCLES = 200_000
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 start,
    input  logic                 pausesw,
    input  logic [NUM_WIRES-1:0] wire_sw,
    input  logic [2:0]           wire_to_cut,
    output logic [1:0]           state_o,
    output logic [STRIKE_W-1:0]  strikes,
    output logic                 strike_pulse,
    output logic [TIME_W-1:0]    time_left
);

    localparam int PRESC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_HZ - 1);

    state_e               state_q,    state_d;
    logic [STRIKE_W-1:0]  strikes_q,  strikes_d;
    logic [TIME_W-1:0]    time_q,     time_d;
    logic [PRESC_W-1:0]   presc_q,    presc_d;
    logic [NUM_WIRES-1:0] cut_done_q, cut_done_d;
    logic                 pulse_q,    pulse_d;

    logic [NUM_WIRES-1:0] cut_evt;
    logic [NUM_WIRES-1:0] level;
    logic [NUM_WIRES-1:0] evt_new;
    logic [NUM_WIRES-1:0] target_mask;
    logic [STRIKE_W:0]    strikes_inc;
    logic                 tick;
    logic                 timeout;
    logic                 correct;
    logic                 strike;

    switch_cut_detector #(
        .NUM_WIRES       (NUM_WIRES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_detect (
        .clk_i      (CLK),
        .rst_ni     (RST_N),
        .wire_raw_i (wire_sw),
        .cut_evt_o  (cut_evt),
        .level_o    (level)
    );

    // Target out of range (0 or > NUM_WIRES) yields an empty mask, so any
    // event against it can never match and is judged a strike.
    always_comb begin
        target_mask = '0;
        for (int i = 0; i < NUM_WIRES; i++) begin
            target_mask[i] = (wire_to_cut == 3'(i + 1));
        end
    end

    assign evt_new     = cut_evt & ~cut_done_q;
    assign correct     = (evt_new != '0) && (evt_new == target_mask);
    assign strike      = (evt_new != '0) && !correct;
    assign tick        = !pausesw && (presc_q == PRESC_LAST);
    assign timeout     = tick && (time_q == TIME_W'(1));
    assign strikes_inc = {1'b0, strikes_q} + (STRIKE_W + 1)'(1);

    always_comb begin
        state_d    = state_q;
        strikes_d  = strikes_q;
        time_d     = time_q;
        presc_d    = presc_q;
        cut_done_d = cut_done_q;
        pulse_d    = 1'b0;

        if (start) begin
            state_d    = ST_ARMED;
            strikes_d  = '0;
            time_d     = TIME_W'(TIME_SECS);
            presc_d    = '0;
            // Wires already down at arm time must never count as cuts.
            cut_done_d = ~level;
        end else if (state_q == ST_ARMED) begin
            cut_done_d = cut_done_q | evt_new;
            if (!pausesw) begin
                presc_d = tick ? '0 : presc_q + PRESC_W'(1);
            end
            if (tick && (time_q != '0)) begin
                time_d = time_q - TIME_W'(1);
            end
            if (strike) begin
                strikes_d = strikes_inc[STRIKE_W-1:0];
                pulse_d   = 1'b1;
            end
            // Priority: correct cut, then timeout, then strike-out.
            if (correct) begin
                state_d = ST_SOLVED;
                time_d  = time_q;
            end else if (timeout) begin
                state_d = ST_EXPLODED;
            end else if (strike && (strikes_inc >= (STRIKE_W + 1)'(MAX_STRIKES))) begin
                state_d = ST_EXPLODED;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            strikes_q  <= '0;
            time_q     <= TIME_W'(TIME_SECS);
            presc_q    <= '0;
            cut_done_q <= '0;
            pulse_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            strikes_q  <= strikes_d;
            time_q     <= time_d;
            presc_q    <= presc_d;
            cut_done_q <= cut_done_d;
            pulse_q    <= pulse_d;
        end
    end

    assign state_o      = state_q;
    assign strikes      = strikes_q;
    assign strike_pulse = pulse_q;
    assign time_left    = time_q;

endmodule

// File: tb/tb_wire_cut_judge.sv
module tb_wire_cut_judge;

    localparam int NW = 4;
    localparam int TS = 5;
    localparam logic [1:0] S_IDLE = 2'd0, S_ARMED = 2'd1, S_SOLVED = 2'd2, S_EXPL = 2'd3;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          start;
    logic          pausesw;
    logic [NW-1:0] wire_sw;
    logic [2:0]    wire_to_cut;
    logic [1:0]    state_o;
    logic [1:0]    strikes;
    logic          strike_pulse;
    logic [7:0]    time_left;

    int errors = 0;
    int checks = 0;

    wire_cut_judge #(
        .NUM_WIRES(NW), .CLK_HZ(1000), .TIME_SECS(TS), .MAX_STRIKES(3), .DEBOUNCE_CYCLES(4)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .start(start), .pausesw(pausesw), .wire_sw(wire_sw),
        .wire_to_cut(wire_to_cut), .state_o(state_o), .strikes(strikes),
        .strike_pulse(strike_pulse), .time_left(time_left)
    );

    always #5 CLK = ~CLK;

    // Advance n clock edges, leaving time 1 unit past the last edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic run_count(input int n, output int pulses);
        pulses = 0;
        repeat (n) begin
            @(posedge CLK);
            #1;
            if (strike_pulse === 1'b1) pulses++;
        end
    endtask

    task automatic arm();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic settle();
        wire_sw = '1;
        step(10);
    endtask

    task automatic test_reset();
        RST_N = 1'b0; start = 1'b0; pausesw = 1'b0; wire_sw = '1; wire_to_cut = 3'd0;
        step(3);
        checks++; if (state_o !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", state_o, S_IDLE); end
        checks++; if (strikes !== 2'd0) begin errors++; $display("FAIL reset_strikes: got %0d expected 0", strikes); end
        checks++; if (strike_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse: got %0b expected 0", strike_pulse); end
        checks++; if (time_left !== 8'(TS)) begin errors++; $display("FAIL reset_time: got %0d expected %0d", time_left, TS); end
        RST_N = 1'b1;
        settle();
        // IDLE ignores cuts
        wire_sw[1] = 1'b0; step(10);
        checks++; if (state_o !== S_IDLE || strikes !== 2'd0) begin errors++; $display("FAIL idle_ignores_cut: got state %0d strikes %0d expected 0 0", state_o, strikes); end
        settle();
    endtask

    task automatic test_correct_cut();
        arm();
        wire_to_cut = 3'd3;
        wire_sw[2] = 1'b0;
        step(6);
        checks++; if (state_o !== S_ARMED) begin errors++; $display("FAIL correct_latency_early: got %0d expected %0d", state_o, S_ARMED); end
        step(1);
        checks++; if (state_o !== S_SOLVED) begin errors++; $display("FAIL correct_solved: got %0d expected %0d", state_o, S_SOLVED); end
        checks++; if (strikes !== 2'd0) begin errors++; $display("FAIL correct_strikes: got %0d expected 0", strikes); end
        step(1200);
        checks++; if (time_left !== 8'(TS) || state_o !== S_SOLVED) begin errors++; $display("FAIL solved_frozen: got time %0d state %0d expected %0d %0d", time_left, state_o, TS, S_SOLVED); end
        settle();
    endtask

    task automatic test_wrong_then_premature();
        int p;
        arm();
        wire_to_cut = 3'd3;
        wire_sw[0] = 1'b0; run_count(8, p);
        checks++; if (p !== 1 || strikes !== 2'd1) begin errors++; $display("FAIL wrong_wire: got pulses %0d strikes %0d expected 1 1", p, strikes); end
        wire_sw[0] = 1'b1; step(8);
        wire_sw[0] = 1'b0; run_count(8, p);
        checks++; if (p !== 0 || strikes !== 2'd1) begin errors++; $display("FAIL recut_ignored: got pulses %0d strikes %0d expected 0 1", p, strikes); end
        wire_to_cut = 3'd0;
        wire_sw[1] = 1'b0; run_count(8, p);
        checks++; if (p !== 1 || strikes !== 2'd2 || state_o !== S_ARMED) begin errors++; $display("FAIL premature_cut: got pulses %0d strikes %0d state %0d expected 1 2 1", p, strikes, state_o); end
        settle();
    endtask

    task automatic test_strike_out();
        int p;
        arm();
        wire_to_cut = 3'd4;
        wire_sw[0] = 1'b0; run_count(8, p);
        wire_sw[1] = 1'b0; run_count(8, p);
        wire_sw[2] = 1'b0; step(6);
        checks++; if (strikes !== 2'd2 || state_o !== S_ARMED) begin errors++; $display("FAIL strikeout_before: got strikes %0d state %0d expected 2 1", strikes, state_o); end
        step(1);
        checks++; if (strike_pulse !== 1'b1 || strikes !== 2'd3 || state_o !== S_EXPL) begin errors++; $display("FAIL strikeout_cycle: got pulse %0b strikes %0d state %0d expected 1 3 3", strike_pulse, strikes, state_o); end
        wire_sw[3] = 1'b0; run_count(8, p);
        checks++; if (p !== 0 || strikes !== 2'd3 || state_o !== S_EXPL) begin errors++; $display("FAIL after_explode: got pulses %0d strikes %0d state %0d expected 0 3 3", p, strikes, state_o); end
        settle();
    endtask

    task automatic test_timeout();
        arm();
        wire_to_cut = 3'd1;
        for (int k = 1; k <= TS; k++) begin
            step(999);
            checks++; if (time_left !== 8'(TS - k + 1)) begin errors++; $display("FAIL timeout_hold_%0d: got %0d expected %0d", k, time_left, TS - k + 1); end
            step(1);
            checks++; if (time_left !== 8'(TS - k)) begin errors++; $display("FAIL timeout_step_%0d: got %0d expected %0d", k, time_left, TS - k); end
        end
        checks++; if (state_o !== S_EXPL) begin errors++; $display("FAIL timeout_explode: got %0d expected %0d", state_o, S_EXPL); end
        step(1500);
        checks++; if (time_left !== 8'd0 || state_o !== S_EXPL) begin errors++; $display("FAIL timeout_saturate: got time %0d state %0d expected 0 3", time_left, state_o); end
    endtask

    task automatic test_pause();
        arm();
        step(500);
        pausesw = 1'b1;
        step(2500);
        pausesw = 1'b0;
        step(4499);
        checks++; if (state_o !== S_ARMED || time_left !== 8'd1) begin errors++; $display("FAIL pause_before: got state %0d time %0d expected 1 1", state_o, time_left); end
        step(1);
        checks++; if (state_o !== S_EXPL || time_left !== 8'd0) begin errors++; $display("FAIL pause_expiry: got state %0d time %0d expected 3 0", state_o, time_left); end
    endtask

    task automatic test_simultaneous();
        int p;
        arm();
        wire_to_cut = 3'd2;
        wire_sw[0] = 1'b0; wire_sw[1] = 1'b0;
        run_count(10, p);
        checks++; if (p !== 1 || strikes !== 2'd1 || state_o !== S_ARMED) begin errors++; $display("FAIL simultaneous: got pulses %0d strikes %0d state %0d expected 1 1 1", p, strikes, state_o); end
        settle();
    endtask

    task automatic test_priority_timeout();
        arm();
        wire_to_cut = 3'd2;
        step(4993);
        wire_sw[1] = 1'b0;
        step(6);
        checks++; if (state_o !== S_ARMED || time_left !== 8'd1) begin errors++; $display("FAIL prio_before: got state %0d time %0d expected 1 1", state_o, time_left); end
        step(1);
        checks++; if (state_o !== S_SOLVED) begin errors++; $display("FAIL prio_solved: got %0d expected %0d", state_o, S_SOLVED); end
        settle();
    endtask

    task automatic test_async_reset();
        int p;
        arm();
        wire_to_cut = 3'd3;
        wire_sw[0] = 1'b0; run_count(8, p);
        step(1200);
        checks++; if (strikes !== 2'd1 || time_left !== 8'(TS - 1)) begin errors++; $display("FAIL pre_reset: got strikes %0d time %0d expected 1 %0d", strikes, time_left, TS - 1); end
        #2 RST_N = 1'b0;
        #1;
        checks++; if (state_o !== S_IDLE || strikes !== 2'd0 || strike_pulse !== 1'b0 || time_left !== 8'(TS)) begin
            errors++; $display("FAIL async_reset: got state %0d strikes %0d pulse %0b time %0d expected 0 0 0 %0d", state_o, strikes, strike_pulse, time_left, TS);
        end
        step(2);
        RST_N = 1'b1;
        settle();
    endtask

    task automatic test_bounce_and_precut();
        arm();
        wire_to_cut = 3'd3;
        wire_sw[0] = 1'b0; step(3); wire_sw[0] = 1'b1; step(10);
        checks++; if (strikes !== 2'd0 || state_o !== S_ARMED) begin errors++; $display("FAIL glitch_3: got strikes %0d state %0d expected 0 1", strikes, state_o); end
        wire_sw[0] = 1'b0; step(4); wire_sw[0] = 1'b1; step(10);
        checks++; if (strikes !== 2'd1) begin errors++; $display("FAIL glitch_4: got strikes %0d expected 1", strikes); end
        settle();
        wire_sw[3] = 1'b0; step(10);
        arm();
        wire_to_cut = 3'd4;
        step(10);
        checks++; if (strikes !== 2'd0 || state_o !== S_ARMED) begin errors++; $display("FAIL precut_arm: got strikes %0d state %0d expected 0 1", strikes, state_o); end
        wire_sw[3] = 1'b1; step(10);
        wire_sw[3] = 1'b0; step(10);
        checks++; if (strikes !== 2'd0 || state_o !== S_ARMED) begin errors++; $display("FAIL precut_recut: got strikes %0d state %0d expected 0 1", strikes, state_o); end
        settle();
    endtask

    // Random games: random target (including 0 and out-of-range) and a
    // random sequence of distinct cuts, judged by the game rules directly.
    task automatic test_random_games();
        int order[NW];
        int p, tgt, ncuts, w, tmp, j;
        int exp_strikes, exp_pulses;
        logic [1:0] exp_state;
        for (int r = 0; r < 8; r++) begin
            arm();
            tgt = $urandom_range(0, 7);
            wire_to_cut = 3'(tgt);
            for (int i = 0; i < NW; i++) order[i] = i;
            for (int i = NW - 1; i > 0; i--) begin
                j = $urandom_range(0, i);
                tmp = order[i]; order[i] = order[j]; order[j] = tmp;
            end
            ncuts = $urandom_range(1, NW);
            exp_state = S_ARMED;
            exp_strikes = 0;
            for (int c = 0; c < ncuts; c++) begin
                w = order[c];
                wire_sw[w] = 1'b0;
                run_count(8, p);
                exp_pulses = 0;
                if (exp_state == S_ARMED) begin
                    if (tgt == w + 1) exp_state = S_SOLVED;
                    else begin
                        exp_strikes++;
                        exp_pulses = 1;
                        if (exp_strikes >= 3) exp_state = S_EXPL;
                    end
                end
                checks++;
                if (state_o !== exp_state || strikes !== 2'(exp_strikes) || p !== exp_pulses) begin
                    errors++;
                    $display("FAIL random_r%0d_c%0d: got state %0d strikes %0d pulses %0d expected %0d %0d %0d",
                             r, c, state_o, strikes, p, exp_state, exp_strikes, exp_pulses);
                end
            end
            settle();
        end
    endtask

    initial begin
        test_reset();
        test_correct_cut();
        test_wrong_then_premature();
        test_strike_out();
        test_timeout();
        test_pause();
        test_simultaneous();
        test_priority_timeout();
        test_async_reset();
        test_bounce_and_precut();
        test_random_games();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
